// File: rtl/conf_feedback_gen.sv
// Feedback level generator for the CONF_<N>BITS inverter configuration block.
// Integrates early/late phase samples per window, decides a correction, settles, and tracks lock.
module conf_feedback_gen #(
  parameter int unsigned WIN_BITS = 4,
  parameter int unsigned THRESH   = 4,
  parameter int unsigned SETTLE   = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ENABLE,
  input  logic                SAMPLE_VLD,
  input  logic                EARLY,
  input  logic                LATE,
  output logic                O_INVU,
  output logic                O_INVD,
  output logic                LOCKED,
  output logic                WIN_DONE,
  output logic [WIN_BITS+1:0] SCORE
);

  localparam int unsigned SW = WIN_BITS + 2;
  localparam logic [WIN_BITS-1:0] CNT_LAST  = {WIN_BITS{1'b1}};
  localparam logic [7:0]          SETL_LAST = 8'(SETTLE - 1);
  localparam logic [3:0]          LOCK_W    = 4'(LOCK_CNT);
  localparam logic signed [SW-1:0] THR_P    = SW'(THRESH);
  localparam logic signed [SW-1:0] THR_N    = -THR_P;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DECIDE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic signed [SW-1:0]  acc_q, acc_d;
  logic signed [SW-1:0]  score_q, score_d;
  logic [WIN_BITS-1:0]   cnt_q, cnt_d;
  logic [7:0]            settle_q, settle_d;
  logic [3:0]            bal_q, bal_d;
  logic                  invu_q, invu_d;
  logic                  invd_q, invd_d;
  logic                  locked_q, locked_d;
  logic                  win_done_q, win_done_d;

  // Next-state and next-output logic; ENABLE low overrides every state.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    score_d    = score_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    bal_d      = bal_q;
    invu_d     = invu_q;
    invd_d     = invd_q;
    locked_d   = locked_q;
    win_done_d = 1'b0;

    if (!ENABLE) begin
      state_d  = S_IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      settle_d = '0;
      bal_d    = '0;
      invu_d   = 1'b0;
      invd_d   = 1'b0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ACCUM;

        S_ACCUM: begin
          if (SAMPLE_VLD) begin
            if (EARLY && !LATE) begin
              acc_d = acc_q + SW'(1);
            end else if (LATE && !EARLY) begin
              acc_d = acc_q - SW'(1);
            end
            // Counter wraps to zero on the last sample, ready for the next window.
            cnt_d = cnt_q + WIN_BITS'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = S_DECIDE;
            end
          end
        end

        S_DECIDE: begin
          score_d    = acc_q;
          win_done_d = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
          settle_d   = '0;
          state_d    = S_HOLD;
          if (acc_q > THR_P) begin
            invu_d   = 1'b1;
            invd_d   = 1'b0;
            bal_d    = '0;
            locked_d = 1'b0;
          end else if (acc_q < THR_N) begin
            invu_d   = 1'b0;
            invd_d   = 1'b1;
            bal_d    = '0;
            locked_d = 1'b0;
          end else begin
            invu_d   = 1'b0;
            invd_d   = 1'b0;
            bal_d    = (bal_q < LOCK_W) ? bal_q + 4'd1 : bal_q;
            locked_d = (bal_d == LOCK_W);
          end
        end

        S_HOLD: begin
          if (settle_q == SETL_LAST) begin
            settle_d = '0;
            state_d  = S_ACCUM;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      score_q    <= '0;
      cnt_q      <= '0;
      settle_q   <= '0;
      bal_q      <= '0;
      invu_q     <= 1'b0;
      invd_q     <= 1'b0;
      locked_q   <= 1'b0;
      win_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      score_q    <= score_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      bal_q      <= bal_d;
      invu_q     <= invu_d;
      invd_q     <= invd_d;
      locked_q   <= locked_d;
      win_done_q <= win_done_d;
    end
  end

  assign O_INVU   = invu_q;
  assign O_INVD   = invd_q;
  assign LOCKED   = locked_q;
  assign WIN_DONE = win_done_q;
  assign SCORE    = score_q;

endmodule

// File: tb/tb_conf_feedback_gen.sv
// Directed plus randomized bench for conf_feedback_gen against a window-level reference model.
module tb_conf_feedback_gen;

  localparam int WIN_BITS = 4;
  localparam int NSAMP    = 16;
  localparam int THRESH   = 4;
  localparam int SETTLE   = 8;
  localparam int LOCK_CNT = 2;

  logic       CLK;
  logic       RST_N;
  logic       ENABLE;
  logic       SAMPLE_VLD;
  logic       EARLY;
  logic       LATE;
  logic       O_INVU;
  logic       O_INVD;
  logic       LOCKED;
  logic       WIN_DONE;
  logic [5:0] SCORE;

  int checks = 0;
  int errors = 0;

  // Reference model state: balance run length and expected outputs.
  int         bal = 0;
  logic       exp_u = 1'b0;
  logic       exp_d = 1'b0;
  logic       exp_l = 1'b0;
  logic [5:0] exp_score = 6'h00;

  conf_feedback_gen #(
    .WIN_BITS(WIN_BITS), .THRESH(THRESH), .SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .SAMPLE_VLD(SAMPLE_VLD),
    .EARLY(EARLY), .LATE(LATE), .O_INVU(O_INVU), .O_INVD(O_INVD),
    .LOCKED(LOCKED), .WIN_DONE(WIN_DONE), .SCORE(SCORE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_invu"},   32'(O_INVU),  32'(exp_u));
    chk({tag, "_invd"},   32'(O_INVD),  32'(exp_d));
    chk({tag, "_locked"}, 32'(LOCKED),  32'(exp_l));
    chk({tag, "_score"},  32'(SCORE),   32'(exp_score));
  endtask

  task automatic model_decide(input int s);
    exp_score = 6'(s);
    if (s > THRESH) begin
      exp_u = 1'b1; exp_d = 1'b0; bal = 0; exp_l = 1'b0;
    end else if (s < -THRESH) begin
      exp_u = 1'b0; exp_d = 1'b1; bal = 0; exp_l = 1'b0;
    end else begin
      exp_u = 1'b0; exp_d = 1'b0;
      if (bal < LOCK_CNT) bal++;
      exp_l = (bal == LOCK_CNT);
    end
  endtask

  task automatic model_clear();
    bal = 0; exp_u = 1'b0; exp_d = 1'b0; exp_l = 1'b0;
  endtask

  // Step one clock, returning at the following falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Drives n valid samples (with optional random gaps); WIN_DONE must stay low throughout.
  task automatic drive_samples(input string tag, input logic [15:0] e_bits,
                               input logic [15:0] l_bits, input int n,
                               input int gap_pct, output int s);
    s = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 3; g++) begin
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          SAMPLE_VLD = 1'b0;
          EARLY = 1'($urandom);
          LATE  = 1'($urandom);
          step();
          chk({tag, "_gap_nodone"}, 32'(WIN_DONE), 32'd0);
        end
      end
      SAMPLE_VLD = 1'b1;
      EARLY = e_bits[i];
      LATE  = l_bits[i];
      if (e_bits[i] && !l_bits[i]) s++;
      else if (l_bits[i] && !e_bits[i]) s--;
      step();
      chk({tag, "_nodone"}, 32'(WIN_DONE), 32'd0);
    end
    SAMPLE_VLD = 1'b0;
    EARLY = 1'b0;
    LATE  = 1'b0;
  endtask

  // Full window from ACCUM: samples, decision two clocks after the last sample, then HOLD.
  task automatic run_window(input string tag, input logic [15:0] e_bits,
                            input logic [15:0] l_bits, input int gap_pct,
                            input bit hold_noise);
    int s;
    drive_samples(tag, e_bits, l_bits, NSAMP, gap_pct, s);
    model_decide(s);
    step();
    chk({tag, "_done"}, 32'(WIN_DONE), 32'd1);
    chk_outs(tag);
    chk({tag, "_excl"}, 32'(O_INVU & O_INVD), 32'd0);
    for (int i = 0; i < SETTLE; i++) begin
      SAMPLE_VLD = hold_noise;
      EARLY = 1'b1;
      LATE  = 1'b0;
      step();
      if (i == 0) chk({tag, "_pulse1"}, 32'(WIN_DONE), 32'd0);
    end
    SAMPLE_VLD = 1'b0;
    EARLY = 1'b0;
    chk_outs({tag, "_held"});
  endtask

  initial begin
    int s7;
    logic [15:0] e;
    logic [15:0] l;
    int mode;

    RST_N = 1'b0; ENABLE = 1'b0; SAMPLE_VLD = 1'b0; EARLY = 1'b0; LATE = 1'b0;
    #12;
    chk("rst_done", 32'(WIN_DONE), 32'd0);
    chk_outs("rst");
    @(negedge CLK);
    RST_N = 1'b1;
    ENABLE = 1'b1;
    step();

    run_window("t1_early", 16'hFFFF, 16'h0000, 0, 1'b0);
    run_window("t2_late",  16'h0000, 16'hFFFF, 0, 1'b0);
    chk("t2_score_lit", 32'(SCORE), 32'h30);

    run_window("t3_bal_a", 16'h03FF, 16'hFC00, 0, 1'b0);
    run_window("t3_bal_b", 16'h03FF, 16'hFC00, 0, 1'b0);
    chk("t3_locked_lit", 32'(LOCKED), 32'd1);
    run_window("t3_unlock", 16'hFFFF, 16'h0000, 0, 1'b0);

    run_window("t4_both", 16'hFFFF, 16'hFFFF, 40, 1'b1);
    run_window("t4_next", 16'h00FF, 16'h0000, 0, 1'b0);

    // Reset asserted mid-window, between clock edges.
    run_window("t5_pre", 16'hFFFF, 16'h0000, 0, 1'b0);
    drive_samples("t5_part", 16'hFFFF, 16'h0000, 7, 0, s7);
    #2;
    RST_N = 1'b0;
    #1;
    model_clear();
    exp_score = 6'h00;
    chk("t5_rst_done", 32'(WIN_DONE), 32'd0);
    chk_outs("t5_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    run_window("t5_fresh", 16'h0000, 16'hFFFF, 0, 1'b0);

    // Lock, then drop ENABLE for one cycle.
    run_window("t6_a", 16'h0000, 16'h0000, 0, 1'b0);
    run_window("t6_b", 16'h0F0F, 16'hF0F0, 0, 1'b0);
    chk("t6_locked", 32'(LOCKED), 32'd1);
    ENABLE = 1'b0;
    step();
    model_clear();
    chk_outs("t6_dis");
    ENABLE = 1'b1;
    step();
    run_window("t6_restart", 16'hFFFF, 16'h0000, 30, 1'b1);

    for (int w = 0; w < 30; w++) begin
      mode = int'($urandom_range(3));
      case (mode)
        0: begin e = 16'($urandom); l = 16'($urandom); end
        1: begin e = 16'($urandom | $urandom); l = 16'($urandom & $urandom); end
        2: begin e = 16'($urandom & $urandom); l = 16'($urandom | $urandom); end
        default: begin e = 16'($urandom); l = e ^ 16'($urandom & $urandom & $urandom); end
      endcase
      run_window("rand", e, l, int'($urandom_range(40)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
